// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer and the ALU decoder
// that hands M-extension instructions over to it.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude-based shift-add multiply / restoring divide with sign fix-up on output.
// The accumulator holds {product-high, multiplier} or {remainder, dividend/quotient}.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             fast_i,
    input  logic             step_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] result_o
);

    logic [2:0]         f3_q, f3_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               fast_q, fast_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, fast_val;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        a_neg = a_is_signed(funct3_i) & op_a_i[WIDTH-1];
        b_neg = b_is_signed(funct3_i) & op_b_i[WIDTH-1];
        mag_a = a_neg ? -op_a_i : op_a_i;
        mag_b = b_neg ? -op_b_i : op_b_i;
        // Fast path covers divide-by-zero and the single signed overflow case.
        if (funct3_i[1])
            fast_val = (op_b_i == '0) ? op_a_i : '0;
        else
            fast_val = (op_b_i == '0) ? '1 : op_a_i;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge   = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= opnd_q);
        rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
        div_next = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        f3_d    = f3_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        fast_d  = fast_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        if (load_i) begin
            f3_d    = funct3_i;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            fast_d  = fast_i;
            opnd_d  = funct3_i[2] ? mag_b : mag_a;
            if (fast_i)
                acc_d = {{WIDTH{1'b0}}, fast_val};
            else
                acc_d = {{WIDTH{1'b0}}, (funct3_i[2] ? mag_a : mag_b)};
        end else if (step_i) begin
            acc_d = f3_q[2] ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            fast_q  <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
        end else begin
            f3_q    <= f3_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            fast_q  <= fast_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
        end
    end

    // Remainder follows the dividend's sign; product and quotient follow the sign mismatch.
    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo  = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (fast_q)
            result_o = acc_q[WIDTH-1:0];
        else if (f3_q[2])
            result_o = f3_q[1] ? rem : quo;
        else if (f3_q == F3_MUL)
            result_o = prod[WIDTH-1:0];
        else
            result_o = prod[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage control for RV32M: accepts an M instruction, stalls the front end while
// the datapath iterates, then presents the result for exactly one cycle.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept, fast, div_zero, div_ovf;
    logic [WIDTH-1:0] dp_result;

    always_comb begin
        accept   = (state_q == IDLE) & start & ~flush;
        div_zero = (op_b == '0);
        div_ovf  = funct3[2] & ~funct3[0]
                 & (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (op_b == '1);
        fast     = funct3[2] & (div_zero | div_ovf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    // Stall is masked by reset so a still-held start cannot freeze a pipeline under reset.
    always_comb begin
        stall  = reset & (accept | (state_q == CALC));
        done   = (state_q == DONE) & ~flush;
        result = done ? dp_result : '0;
    end

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (accept),
        .fast_i   (fast),
        .step_i   (state_q == CALC),
        .funct3_i (funct3),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .result_o (dp_result)
    );

endmodule
